systolic_job_queue: RTL and testbench

Host-side command front-end that sits directly upstream of the systolic controller. It accepts matrix-multiply job descriptors over a valid/ready interface and buffers them in a small FIFO. It launches one job at a time on the controller's new_data/addr/n interface, tracks completion and overflow, and applies a run watchdog. Each finished job produces a completion record on a valid/ready response port.

---
 rtl/systolic_job_queue.sv | 177 +++++++++++++++++
 tb/tb_systolic_job_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_job_queue.sv
// Job front-end for the systolic controller: buffers descriptors in a small FIFO,
// launches them one at a time, watches for completion/hang and returns a record per job.
module systolic_job_queue #(
    parameter int DEPTH   = 4,
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_tag,
    input  logic [11:0]              cmd_addr_a,
    input  logic [11:0]              cmd_addr_b,
    input  logic [11:0]              cmd_addr_c,
    input  logic [3:0]               cmd_n,
    input  logic                     cmd_step,
    output logic                     new_data,
    output logic [11:0]              addr_A,
    output logic [11:0]              addr_B,
    output logic [11:0]              addr_C,
    output logic [3:0]               n,
    output logic                     stepping_enable,
    input  logic                     done,
    input  logic [15:0]              total_cycles,
    input  logic                     overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_tag,
    output logic [15:0]              rsp_cycles,
    output logic                     rsp_overflow,
    output logic                     rsp_timeout,
    output logic                     err_bad_n,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [4:0]      N_MAX   = 5'(N);

    typedef struct packed {
        logic [3:0]  tag;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] c;
        logic [3:0]  n;
        logic        step;
    } job_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        RUN,
        REPORT
    } state_t;

    state_t            state_q, state_d;
    job_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic              n_ok, push, bad, pop;
    logic              sticky_ovf;
    logic [WD_W-1:0]   wdog;
    logic              wd_en, expire;

    assign cmd_ready = (cnt != CW'(DEPTH));
    assign n_ok      = (cmd_n != 4'd0) && ({1'b0, cmd_n} <= N_MAX);
    assign push      = cmd_valid && cmd_ready && n_ok;
    assign bad       = cmd_valid && cmd_ready && !n_ok;
    assign pop       = (state_q == IDLE) && (cnt != '0);
    assign busy      = (state_q != IDLE) || (cnt != '0);
    assign count     = cnt;

    // Watchdog only runs for free-running jobs; a stepped job may legitimately stall.
    assign wd_en  = (TIMEOUT != 0) && !stepping_enable;
    assign expire = wd_en && (wdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: cmd_tag, a: cmd_addr_a, b: cmd_addr_b,
                             c: cmd_addr_c, n: cmd_n, step: cmd_step};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            err_bad_n <= 1'b0;
        end else begin
            err_bad_n <= bad;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        new_data  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:     if (cnt != '0) state_d = LAUNCH;
            LAUNCH: begin
                new_data = 1'b1;
                state_d  = WAIT_ACK;
            end
            // done may still be high from the previous job right after launch
            WAIT_ACK: if (!done) state_d = RUN;
            RUN:      if (done || expire) state_d = REPORT;
            REPORT: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_tag         <= '0;
            addr_A          <= '0;
            addr_B          <= '0;
            addr_C          <= '0;
            n               <= '0;
            stepping_enable <= 1'b0;
            rsp_cycles      <= '0;
            rsp_overflow    <= 1'b0;
            rsp_timeout     <= 1'b0;
            sticky_ovf      <= 1'b0;
            wdog            <= '0;
        end else begin
            if (pop) begin
                rsp_tag         <= mem[rd_ptr].tag;
                addr_A          <= mem[rd_ptr].a;
                addr_B          <= mem[rd_ptr].b;
                addr_C          <= mem[rd_ptr].c;
                n               <= mem[rd_ptr].n;
                stepping_enable <= mem[rd_ptr].step;
            end
            if (state_q == LAUNCH) begin
                sticky_ovf <= 1'b0;
                wdog       <= '0;
            end
            // Completion beats watchdog expiry when both land on the same cycle.
            if (state_q == RUN) begin
                if (done) begin
                    rsp_cycles   <= total_cycles;
                    rsp_overflow <= sticky_ovf | overflow;
                    rsp_timeout  <= 1'b0;
                end else if (expire) begin
                    rsp_cycles   <= total_cycles;
                    rsp_overflow <= sticky_ovf | overflow;
                    rsp_timeout  <= 1'b1;
                end else begin
                    sticky_ovf <= sticky_ovf | overflow;
                    if (wd_en) wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_job_queue.sv
// Randomized bench for systolic_job_queue: a transaction-level queue model plus a
// small controller model; every cycle the DUT outputs are compared against the model.
module tb_systolic_job_queue;

    localparam int DEPTH   = 4;
    localparam int N       = 4;
    localparam int TIMEOUT = 1024;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_step;
    logic [3:0]  cmd_tag, cmd_n;
    logic [11:0] cmd_addr_a, cmd_addr_b, cmd_addr_c;
    logic        new_data, stepping_enable;
    logic [11:0] addr_A, addr_B, addr_C;
    logic [3:0]  n;
    logic        done, overflow;
    logic [15:0] total_cycles;
    logic        rsp_valid, rsp_ready, rsp_overflow, rsp_timeout;
    logic [3:0]  rsp_tag;
    logic [15:0] rsp_cycles;
    logic        err_bad_n, busy;
    logic [2:0]  count;

    systolic_job_queue #(.DEPTH(DEPTH), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_c(cmd_addr_c),
        .cmd_n(cmd_n), .cmd_step(cmd_step),
        .new_data(new_data), .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C),
        .n(n), .stepping_enable(stepping_enable),
        .done(done), .total_cycles(total_cycles), .overflow(overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_cycles(rsp_cycles), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .err_bad_n(err_bad_n), .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A job plus the controller behaviour planned for it.
    typedef struct {
        logic [3:0]  tag;
        logic [11:0] a, b, c;
        logic [3:0]  n;
        logic        step;
        int          dur;
        bit          ack;
        int          ovf_at;
        bit          hang;
    } job_rec_t;

    job_rec_t fifo_q[$];
    job_rec_t cmd_job, act_job, cur;
    int  tests = 0, fails = 0;
    int  cyc = 0, launch_cyc = 0;
    bit  launch_valid = 0, active = 0, bad_pending = 0, prev_rv = 0, hold_ready = 0;
    int  e_cycles, e_rise;
    bit  e_ovf, e_to;
    int  max_count = 0, n_launch = 0, n_rsp = 0, n_err = 0;
    int  last_hs_cyc = 0, last_launch_cyc = 0, last_rise_cyc = 0;
    int  last_tag = 0, last_cycles = 0;
    bit  last_ovf = 0, last_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller model: drops done after launch (optionally one cycle late), raises it
    // after dur cycles with total_cycles=dur, or never raises it for a hung job.
    initial begin
        done = 1'b1; total_cycles = '0; overflow = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!launch_valid) begin
                done = 1'b1; total_cycles = '0; overflow = 1'b0;
            end else begin
                int k;
                k = cyc - launch_cyc;
                overflow = (cur.ovf_at != 0) && (k == cur.ovf_at);
                if (k <= 1) begin
                    done = cur.ack; total_cycles = '0;
                end else if (!cur.hang && k >= 1 + cur.dur) begin
                    done = 1'b1; total_cycles = 16'(cur.dur);
                end else begin
                    done = 1'b0; total_cycles = 16'(k - 1);
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle comparison against the transaction model.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctrl", {new_data, rsp_valid, err_bad_n, busy, count, n, stepping_enable,
                               rsp_tag, rsp_cycles, rsp_overflow, rsp_timeout}, '0);
            chk("reset_addr", {addr_A, addr_B, addr_C}, '0);
            fifo_q.delete();
            active = 0; launch_valid = 0; bad_pending = 0; prev_rv = 0;
        end else begin
            if (new_data) begin
                n_launch++;
                chk("launch_while_active", active, 0);
                if (fifo_q.size() == 0) begin
                    chk("launch_without_job", fifo_q.size(), 1);
                end else begin
                    act_job = fifo_q.pop_front();
                    chk("launch_fields", {addr_A, addr_B, addr_C, n, stepping_enable},
                        {act_job.a, act_job.b, act_job.c, act_job.n, act_job.step});
                    if (act_job.hang) begin
                        e_to = 1; e_ovf = 0;
                        e_cycles = TIMEOUT + int'(act_job.ack);
                        e_rise = cyc + 2 + int'(act_job.ack) + TIMEOUT;
                    end else begin
                        e_to = 0; e_ovf = (act_job.ovf_at != 0);
                        e_cycles = act_job.dur;
                        e_rise = cyc + 2 + act_job.dur;
                    end
                    active = 1; cur = act_job; launch_cyc = cyc; launch_valid = 1;
                    last_launch_cyc = cyc;
                end
            end else if (active) begin
                chk("launch_hold", {addr_A, addr_B, addr_C, n, stepping_enable},
                    {act_job.a, act_job.b, act_job.c, act_job.n, act_job.step});
            end
            chk("err_bad_n", err_bad_n, bad_pending);
            if (err_bad_n) n_err++;
            chk("count", count, fifo_q.size());
            chk("cmd_ready", cmd_ready, fifo_q.size() != DEPTH);
            chk("busy", busy, (fifo_q.size() != 0) || active);
            if (int'(count) > max_count) max_count = int'(count);
            if (rsp_valid) begin
                if (!active) begin
                    chk("rsp_without_job", active, 1);
                end else begin
                    if (!prev_rv) begin
                        chk("rsp_latency", cyc, e_rise);
                        last_rise_cyc = cyc;
                    end
                    chk("rsp_tag", rsp_tag, act_job.tag);
                    chk("rsp_cycles", rsp_cycles, e_cycles);
                    chk("rsp_overflow", rsp_overflow, e_ovf);
                    chk("rsp_timeout", rsp_timeout, e_to);
                    if (rsp_ready) begin
                        n_rsp++;
                        last_tag = int'(rsp_tag); last_cycles = int'(rsp_cycles);
                        last_ovf = rsp_overflow; last_to = rsp_timeout;
                        active = 0;
                    end
                end
            end else if (active && !prev_rv && cyc == e_rise) begin
                chk("rsp_missing", rsp_valid, 1);
            end
            prev_rv = rsp_valid;
            bad_pending = 0;
            if (cmd_valid && cmd_ready) begin
                last_hs_cyc = cyc;
                if (cmd_n == 0 || cmd_n > N) bad_pending = 1;
                else fifo_q.push_back(cmd_job);
            end
        end
    end

    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push(input logic [3:0] tag, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [3:0] nn, input bit step,
                        input int dur, input bit ack, input int ovf_at, input bit hang);
        cmd_job.tag = tag; cmd_job.a = a; cmd_job.b = b; cmd_job.c = c; cmd_job.n = nn;
        cmd_job.step = step; cmd_job.dur = dur; cmd_job.ack = ack;
        cmd_job.ovf_at = ovf_at; cmd_job.hang = hang;
        cmd_tag = tag; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_c = c;
        cmd_n = nn; cmd_step = step; cmd_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
            if (i >= 3000) begin
                chk("push_wait", cmd_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (fifo_q.size() == 0 && !active) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
        tick(2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int l0, e0, r0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_tag = '0; cmd_n = '0; cmd_step = 1'b0;
        cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_c = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("ready_after_reset", cmd_ready, 1);

        // Single job, 40-cycle run
        push(4'd3, 12'h000, 12'h010, 12'h020, 4'd4, 0, 40, 0, 0, 0);
        wait_idle(300);
        chk("t1_launch_latency", last_launch_cyc - last_hs_cyc, 2);
        chk("t1_tag", last_tag, 3);
        chk("t1_cycles", last_cycles, 40);
        chk("t1_ovf_to", {last_ovf, last_to}, 2'b00);

        // Back-to-back jobs fill the FIFO while the first one runs
        r0 = n_rsp;
        push(4'd1, 12'h100, 12'h200, 12'h300, 4'd4, 0, 60, 1, 0, 0);
        for (int t = 2; t <= 6; t++)
            push(4'(t), 12'(t * 16), 12'(t * 32), 12'(t * 48), 4'($urandom_range(1, 4)),
                 0, $urandom_range(5, 15), 0, 0, 0);
        wait_idle(2000);
        chk("t2_max_count", max_count, 4);
        chk("t2_responses", n_rsp - r0, 6);

        // Illegal sizes are handshaken and dropped
        l0 = n_launch; e0 = n_err;
        push(4'd5, 12'h001, 12'h002, 12'h003, 4'd0, 0, 10, 0, 0, 0);
        push(4'd6, 12'h004, 12'h005, 12'h006, 4'd5, 0, 10, 0, 0, 0);
        tick(4);
        chk("t3_err_pulses", n_err - e0, 2);
        chk("t3_no_launch", n_launch - l0, 0);
        chk("t3_count", count, 0);

        // Single-cycle overflow is sticky for that job only
        push(4'd7, 12'h111, 12'h222, 12'h333, 4'd3, 0, 20, 0, 6, 0);
        wait_idle(300);
        chk("t4_ovf_set", last_ovf, 1);
        push(4'd8, 12'h444, 12'h555, 12'h666, 4'd3, 0, 20, 0, 0, 0);
        wait_idle(300);
        chk("t4_ovf_clear", last_ovf, 0);

        // Hung job times out; the same hang in stepping mode does not
        push(4'd9, 12'h0a0, 12'h0b0, 12'h0c0, 4'd2, 0, 0, 0, 0, 1);
        wait_idle(3000);
        chk("t5_timeout", last_to, 1);
        chk("t5_cycles", last_cycles, 1024);
        chk("t5_timeout_latency", last_rise_cyc - last_launch_cyc, 1026);
        push(4'd10, 12'h0d0, 12'h0e0, 12'h0f0, 4'd2, 1, 1100, 0, 0, 0);
        wait_idle(3000);
        chk("t5_step_no_timeout", last_to, 0);
        chk("t5_step_cycles", last_cycles, 1100);

        // Backpressure on the response port blocks further launches
        hold_ready = 1;
        push(4'd11, 12'h123, 12'h456, 12'h789, 4'd4, 0, 10, 0, 0, 0);
        push(4'd12, 12'h321, 12'h654, 12'h987, 4'd1, 0, 10, 1, 0, 0);
        for (int i = 0; i < 200 && !rsp_valid; i++) tick(1);
        l0 = n_launch;
        tick(10);
        chk("t6_rsp_held", rsp_valid, 1);
        chk("t6_no_launch", n_launch - l0, 0);
        hold_ready = 0;
        wait_idle(300);

        // Reset in the middle of a run discards everything
        push(4'd13, 12'h0aa, 12'h0bb, 12'h0cc, 4'd4, 0, 100, 0, 0, 0);
        push(4'd14, 12'h0dd, 12'h0ee, 12'h0ff, 4'd4, 0, 10, 0, 0, 0);
        tick(15);
        rst = 1'b1;
        tick(3);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_new_data", new_data, 0);
        rst = 1'b0;
        tick(2);
        push(4'd15, 12'h010, 12'h020, 12'h030, 4'd2, 0, 8, 0, 0, 0);
        wait_idle(300);
        chk("t6_recover_tag", last_tag, 15);

        // Randomized traffic
        for (int j = 0; j < 40; j++) begin
            int d;
            d = $urandom_range(3, 30);
            push(4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                 4'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), d,
                 $urandom_range(0, 1) != 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(4, d + 1) : 0, 0);
            tick($urandom_range(0, 3));
        end
        wait_idle(5000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
